fp_vector_runner: RTL and testbench

- Synthesizable on-chip test sequencer for the single-precision FP adder; hardware counterpart of the simulation bench.
- Steps through a synchronous vector ROM. Each 96-bit entry is {A, B, expected}.
- Drives the adder operands, waits the adder latency, compares the result bit-exactly, and reports error count plus first-failure info for board-level (Zedboard) checkout.

---
 rtl/fp_vector_runner.sv | 104 ++++++++++
 tb/tb_fp_vector_runner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_vector_runner.sv
// fp_vector_runner: on-chip sequencer that replays {A, B, expected} vectors from a
// synchronous ROM through an external FP adder and tallies bit-exact mismatches.
module fp_vector_runner #(
    parameter int NUM    = 10,
    parameter int ADDR_W = 4,
    parameter int LAT    = 2,
    parameter int NAN_EQ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [95:0]       vec_data,
    output logic [31:0]       reg_A,
    output logic [31:0]       reg_B,
    input  logic [31:0]       out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [31:0]       first_err_got
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, CHECK, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_exp;
    logic [ADDR_W-1:0] r_idx;

    logic        w_nan_out, w_nan_exp, w_match, w_last;
    logic [15:0] w_err_next;

    assign w_nan_out  = (out[30:23] == 8'hFF) && (out[22:0] != 23'd0);
    assign w_nan_exp  = (r_exp[30:23] == 8'hFF) && (r_exp[22:0] != 23'd0);
    assign w_match    = (out == r_exp) || ((NAN_EQ != 0) && w_nan_out && w_nan_exp);
    assign w_last     = r_idx == ADDR_W'(NUM - 1);
    assign w_err_next = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    assign vec_addr   = r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_exp         <= '0;
            r_idx         <= '0;
            reg_A         <= '0;
            reg_B         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_state       <= FETCH;
                    r_idx         <= '0;
                    busy          <= 1'b1;
                    done          <= 1'b0;
                    pass          <= 1'b0;
                    err_count     <= '0;
                    first_err_idx <= '0;
                    first_err_got <= '0;
                end
                FETCH: r_state <= LOAD;
                LOAD: begin
                    reg_A   <= vec_data[95:64];
                    reg_B   <= vec_data[63:32];
                    r_exp   <= vec_data[31:0];
                    r_cnt   <= CW'(LAT);
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= CHECK;
                end
                CHECK: begin
                    // a zero count means no earlier failure, since the count saturates
                    if (!w_match) begin
                        err_count <= w_err_next;
                        if (err_count == 16'd0) begin
                            first_err_idx <= r_idx;
                            first_err_got <= out;
                        end
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= w_match && (err_count == 16'd0);
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_vector_runner.sv
// tb_fp_vector_runner: drives two runners (strict and NaN-tolerant) from a shared ROM
// with a pipelined stand-in adder and checks run results against a vector-level model.
module tb_fp_vector_runner;
    localparam int NUM = 3;
    localparam int LAT = 2;
    localparam int PER = 3 + LAT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [95:0] rom [16];
    logic [1:0]  st = 2'b00;
    logic [3:0]  va [2];
    logic [95:0] vd [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [31:0] ao [2];
    logic [31:0] pipe [2][LAT];
    logic        bz [2];
    logic        dn [2];
    logic        ps [2];
    logic [15:0] ec [2];
    logic [3:0]  fi [2];
    logic [31:0] fg [2];

    int total = 0;
    int bad = 0;

    function automatic logic isnan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // stand-in adder: exact sums for the directed vectors, quiet NaN on NaN input, bit-mix otherwise
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (isnan(a) || isnan(b)) return 32'h7FC00000;
        case ({a, b})
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_C0000000: return 32'h00000000;
            64'h3FC00000_3FC00000: return 32'h40400000;
            default:               return a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            vd[k]      <= rom[va[k]];
            pipe[k][0] <= fadd(ra[k], rb[k]);
            for (int j = 1; j < LAT; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) ao[k] = pipe[k][LAT-1];
    end

    for (genvar g = 0; g < 2; g++) begin : g_u
        fp_vector_runner #(.NUM(NUM), .ADDR_W(4), .LAT(LAT), .NAN_EQ(g)) u_dut (
            .clk(clk), .reset(rst_n), .start(st[g]), .vec_addr(va[g]), .vec_data(vd[g]),
            .reg_A(ra[g]), .reg_B(rb[g]), .out(ao[g]), .busy(bz[g]), .done(dn[g]),
            .pass(ps[g]), .err_count(ec[g]), .first_err_idx(fi[g]), .first_err_got(fg[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        rom[i] = {a, b, e};
    endtask

    task automatic spec_rom();
        set_vec(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
        set_vec(1, 32'h40000000, 32'hC0000000, 32'h00000000);
        set_vec(2, 32'h3FC00000, 32'h3FC00000, 32'h40400000);
    endtask

    task automatic chk_zero(input int u);
        chk("rst_addr", 32'(va[u]), 0);
        chk("rst_A", ra[u], 0);
        chk("rst_B", rb[u], 0);
        chk("rst_busy", 32'(bz[u]), 0);
        chk("rst_done", 32'(dn[u]), 0);
        chk("rst_pass", 32'(ps[u]), 0);
        chk("rst_err", 32'(ec[u]), 0);
        chk("rst_fidx", 32'(fi[u]), 0);
        chk("rst_fgot", fg[u], 0);
    endtask

    // one run on runner u; poke = cycle to raise start mid-run, abort = cycle to pulse reset
    task automatic run(input int u, input int poke, input int abort);
        int e_err = 0, e_idx = 0, cyc = 0, q;
        logic [31:0] e_got = 0, got, ex;
        for (int i = 0; i < NUM; i++) begin
            got = fadd(rom[i][95:64], rom[i][63:32]);
            ex  = rom[i][31:0];
            if (!(got == ex || (u == 1 && isnan(got) && isnan(ex)))) begin
                if (e_err == 0) begin
                    e_idx = i;
                    e_got = got;
                end
                e_err++;
            end
        end
        @(negedge clk) st[u] = 1'b1;
        @(posedge clk);
        #1 st[u] = 1'b0;
        chk("start_done", 32'(dn[u]), 0);
        chk("start_busy", 32'(bz[u]), 1);
        chk("start_err", 32'(ec[u]), 0);
        chk("start_addr", 32'(va[u]), 0);
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == abort) begin
                rst_n = 1'b0;
                #1 chk_zero(u);
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            st[u] = (cyc == poke);
            if (cyc >= 2) begin
                q = (cyc - 2) / PER;
                if (q > NUM - 1) q = NUM - 1;
                chk("opA", ra[u], rom[q][95:64]);
                chk("opB", rb[u], rom[q][63:32]);
            end
            if (dn[u]) break;
            if (cyc > 4 * NUM * PER) begin
                chk("timeout", 32'(cyc), NUM * PER);
                break;
            end
        end
        st[u] = 1'b0;
        chk("done_cyc", 32'(cyc), NUM * PER);
        chk("busy_end", 32'(bz[u]), 0);
        chk("err", 32'(ec[u]), 32'(e_err));
        chk("fidx", 32'(fi[u]), 32'(e_idx));
        chk("fgot", fg[u], e_got);
        chk("pass", 32'(ps[u]), 32'(e_err == 0));
        @(posedge clk);
        #1 chk("done_hold", 32'(dn[u]), 1);
    endtask

    initial begin
        logic [31:0] a, b, e, r;
        for (int i = 0; i < 16; i++) rom[i] = '0;
        repeat (2) @(posedge clk);
        #1 chk_zero(0);
        chk_zero(1);
        @(negedge clk) rst_n = 1'b1;

        spec_rom();
        run(0, 0, 0);
        set_vec(1, 32'h40000000, 32'hC0000000, 32'h00000001);
        run(0, 6, 0);
        run(0, 14, 0);

        spec_rom();
        set_vec(0, 32'h7FC00000, 32'h3F800000, 32'h7FC00001);
        run(0, 0, 0);
        run(1, 0, 0);

        spec_rom();
        set_vec(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        run(0, 0, 7);
        run(0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NUM; i++) begin
                a = $urandom;
                b = $urandom;
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: e = fadd(a, b);
                    1: e = fadd(a, b) ^ (32'd1 << $urandom_range(0, 31));
                    2: begin
                        a = {r[31], 8'hFF, r[22:0] | 23'd1};
                        e = {r[30], 8'hFF, r[29:7] | 23'd4};
                    end
                    default: e = r;
                endcase
                set_vec(i, a, b, e);
            end
            run(n % 2, (n % 3 == 0) ? 9 : 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
